// File: rtl/wordcopy_pkg.sv
// Shared types and constants for the wordcopy_master block-copy engine.
package wordcopy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BE_ALL     = 4'hF;

endpackage

// File: rtl/wordcopy_fifo.sv
// Synchronous read-data buffer: head is visible combinationally, pop advances it.
module wordcopy_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // The master only issues a read when a slot is reserved for its data.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(i_pop && (r_count == '0)));

endmodule

// File: rtl/wordcopy_master.sv
// Avalon-MM initiator copying num_words 32-bit words from src_addr to dst_addr.
// Define WORDCOPY_CHECKSUM_EN to add the checksum output (sum of written words).
module wordcopy_master
    import wordcopy_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest,
    output state_t            dbg_state
`ifdef WORDCOPY_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W:0]    r_rd_issued;
    logic [LEN_W:0]    r_wr_issued;
    logic [OUT_W-1:0]  r_outstanding;
    logic              r_m_read;
    logic              r_m_write;
    logic [ADDR_W-1:0] r_m_address;
    logic              r_done;

    state_t            w_state_nx;
    logic              w_latch;
    logic              w_issue_rd;
    logic              w_issue_wr;
    logic              w_done_nx;
    logic              w_pending;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_req_free;
    logic              w_rvalid;
    logic              w_last_wr;
    logic              w_rd_ok;
    logic [LEN_W:0]    w_rd_issued_nx;
    logic [LEN_W:0]    w_wr_issued_nx;
    logic [LEN_W:0]    w_len_ext;
    logic [OUT_W-1:0]  w_out_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [31:0]       w_head;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // Bus handshake: a request (m_read or m_write, with m_address/m_writedata)
    // stays stable while m_waitrequest=1 and is accepted on the first edge
    // with m_waitrequest=0; at most one request is outstanding on the command bus.
    assign w_pending  = r_m_read | r_m_write;
    assign w_rd_acc   = r_m_read & ~m_waitrequest;
    assign w_wr_acc   = r_m_write & ~m_waitrequest;
    assign w_req_free = ~w_pending | w_rd_acc | w_wr_acc;
    assign w_rvalid   = m_readdatavalid & (r_outstanding != '0);

    assign w_rd_issued_nx = r_rd_issued + (LEN_W+1)'(w_rd_acc);
    assign w_wr_issued_nx = r_wr_issued + (LEN_W+1)'(w_wr_acc);
    assign w_len_ext      = {1'b0, r_len};
    assign w_out_nx       = r_outstanding + OUT_W'(w_rd_acc) - OUT_W'(w_rvalid);
    assign w_cnt_nx       = w_fifo_count + CNT_W'(w_rvalid) - CNT_W'(w_wr_acc);
    assign w_last_wr      = w_wr_acc && (w_wr_issued_nx == w_len_ext);

    assign w_rd_addr = r_src + ADDR_W'(w_rd_issued_nx) * ADDR_W'(WORD_BYTES);
    assign w_wr_addr = r_dst + ADDR_W'(w_wr_issued_nx) * ADDR_W'(WORD_BYTES);

    // Reserve a FIFO slot for every read in flight so returned data never overflows.
    assign w_rd_ok = (w_rd_issued_nx < w_len_ext)
                  && (w_out_nx < OUT_W'(MAX_OUTSTANDING))
                  && ((SUM_W'(w_out_nx) + SUM_W'(w_cnt_nx)) < SUM_W'(FIFO_DEPTH))
                  && !w_fifo_full;

    wordcopy_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rvalid),
        .i_data  (m_readdata),
        .i_pop   (w_wr_acc),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_latch    = 1'b0;
        w_issue_rd = 1'b0;
        w_issue_wr = 1'b0;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_latch = 1'b1;
                    if (num_words != '0) begin
                        w_state_nx = COPY;
                        w_issue_rd = 1'b1;
                    end else begin
                        w_done_nx = 1'b1;
                    end
                end
            end
            COPY: begin
                if (w_last_wr) begin
                    w_state_nx = DONE;
                    w_done_nx  = 1'b1;
                end else if (w_req_free) begin
                    if (w_cnt_nx != '0) begin
                        w_issue_wr = 1'b1;
                    end else if (w_rd_ok) begin
                        w_issue_rd = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b0;
            r_m_address <= '0;
        end else if (w_issue_rd) begin
            r_m_read    <= 1'b1;
            r_m_write   <= 1'b0;
            r_m_address <= w_latch ? src_addr : w_rd_addr;
        end else if (w_issue_wr) begin
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b1;
            r_m_address <= w_wr_addr;
        end else if (w_req_free) begin
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_rd_issued   <= '0;
            r_wr_issued   <= '0;
            r_outstanding <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_done_nx;
            if (w_latch) begin
                r_src         <= src_addr;
                r_dst         <= dst_addr;
                r_len         <= num_words;
                r_rd_issued   <= '0;
                r_wr_issued   <= '0;
                r_outstanding <= '0;
            end else begin
                r_rd_issued   <= w_rd_issued_nx;
                r_wr_issued   <= w_wr_issued_nx;
                r_outstanding <= w_out_nx;
            end
        end
    end

`ifdef WORDCOPY_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_latch) begin
            r_checksum <= '0;
        end else if (w_wr_acc) begin
            r_checksum <= r_checksum + w_head;
        end
    end

    assign checksum = r_checksum;
`endif

    assign busy         = (r_state == COPY);
    assign done         = r_done;
    assign m_read       = r_m_read;
    assign m_write      = r_m_write;
    assign m_address    = r_m_address;
    assign m_writedata  = (r_m_write && !w_fifo_empty) ? w_head : 32'd0;
    assign m_byteenable = BE_ALL;
    assign dbg_state    = r_state;

endmodule
